// File: rtl/ahb_master_pkg.sv
// Shared definitions for the AHB master datapath: FIFO defaults,
// pointer-width helper and the FIFO status bundle.
package ahb_master_pkg;

   localparam int FIFO_WDT_DEF   = 32;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int FIFO_AF_DEF    = 6;

   // Pointer width: index bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic full;
      logic almost_full;
      logic overflow;
   } fifo_status_t;

endpackage

// File: rtl/ahb_master_fifo_ram.sv
// DEPTH x WDT register array: synchronous write, asynchronous read, no reset.
module ahb_master_fifo_ram #(
   parameter int WDT   = 32,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           i_clk,
   input  logic           i_we,
   input  logic [AW-1:0]  i_waddr,
   input  logic [WDT-1:0] i_wdata,
   input  logic [AW-1:0]  i_raddr,
   output logic [WDT-1:0] o_rdata
);

   logic [WDT-1:0] mem [DEPTH];

   // Write port; contents are deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/ahb_master_req_fifo.sv
// Request/write-data FIFO, first-word-fall-through read side.
// The head only moves on a pop, so data/valid hold while stalled, which
// the downstream skid buffer relies on (its stall arrives one cycle late).
module ahb_master_req_fifo
   import ahb_master_pkg::*;
#(
   parameter int WDT       = FIFO_WDT_DEF,
   parameter int DEPTH     = FIFO_DEPTH_DEF,
   parameter int AF_THRESH = FIFO_AF_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_flush,
   input  logic                   i_wr_en,
   input  logic [WDT-1:0]         i_wr_data,
   output logic                   o_full,
   output logic                   o_almost_full,
   output logic                   o_overflow,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_rd_valid,
   output logic [WDT-1:0]         o_rd_data,
   input  logic                   i_stall
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  count_q, count_d;
   fifo_status_t   status_q, status_d;
   logic           empty, push, pop;
   logic [WDT-1:0] ram_rdata;

   assign empty = (wr_ptr_q == rd_ptr_q);
   // Push gates on the registered full flag; a write while full is dropped.
   assign push  = i_wr_en & ~status_q.full;
   assign pop   = ~empty & ~i_stall;

   // Next-state for pointers, occupancy and status; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      status_d = status_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         status_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d              = count_q + PW'(push) - PW'(pop);
         status_d.full        = (count_d == PW'(DEPTH));
         status_d.almost_full = (count_d >= PW'(AF_THRESH));
         status_d.overflow    = status_q.overflow | (i_wr_en & status_q.full);
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         status_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   ahb_master_fifo_ram #(
      .WDT   (WDT),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (push & ~i_flush),
      .i_waddr (wr_ptr_q[AW-1:0]),
      .i_wdata (i_wr_data),
      .i_raddr (rd_ptr_q[AW-1:0]),
      .o_rdata (ram_rdata)
   );

   assign o_full        = status_q.full;
   assign o_almost_full = status_q.almost_full;
   assign o_overflow    = status_q.overflow;
   assign o_count       = count_q;
   assign o_rd_valid    = ~empty;
   assign o_rd_data     = empty ? '0 : ram_rdata;

endmodule

// File: tb/tb_ahb_master_req_fifo.sv
// Bench for ahb_master_req_fifo: directed scenarios plus random traffic,
// checked against a queue-based model of the FIFO contract.
module tb_ahb_master_req_fifo;

   localparam int WDT   = 32;
   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic            i_clk = 1'b0;
   logic            i_reset, i_flush, i_wr_en, i_stall;
   logic [WDT-1:0]  i_wr_data;
   logic            o_full, o_almost_full, o_overflow, o_rd_valid;
   logic [3:0]      o_count;
   logic [WDT-1:0]  o_rd_data;

   int nvec = 0;
   int nerr = 0;

   // Reference model state
   logic [WDT-1:0] q[$];
   logic           m_ovf;

   ahb_master_req_fifo #(.WDT(WDT), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_flush       (i_flush),
      .i_wr_en       (i_wr_en),
      .i_wr_data     (i_wr_data),
      .o_full        (o_full),
      .o_almost_full (o_almost_full),
      .o_overflow    (o_overflow),
      .o_count       (o_count),
      .o_rd_valid    (o_rd_valid),
      .o_rd_data     (o_rd_data),
      .i_stall       (i_stall)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"}, 64'(o_count),       64'(q.size()));
      chk({tag, ".full"},  64'(o_full),        64'(q.size() == DEPTH));
      chk({tag, ".af"},    64'(o_almost_full), 64'(q.size() >= AF));
      chk({tag, ".ovf"},   64'(o_overflow),    64'(m_ovf));
      chk({tag, ".vld"},   64'(o_rd_valid),    64'(q.size() != 0));
      chk({tag, ".data"},  64'(o_rd_data),     (q.size() != 0) ? 64'(q[0]) : 64'd0);
   endtask

   // Contract-level model of one clock edge.
   task automatic model_step(input logic wr, input logic [WDT-1:0] d,
                             input logic st, input logic fl);
      bit was_full;
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         was_full = (q.size() == DEPTH);
         if (wr && was_full) m_ovf = 1'b1;
         if (q.size() != 0 && !st) void'(q.pop_front());
         if (wr && !was_full) q.push_back(d);
      end
   endtask

   // Drive one cycle from a negedge, then check at the following negedge.
   task automatic cyc(input string tag, input logic wr, input logic [WDT-1:0] d,
                      input logic st, input logic fl);
      i_wr_en   = wr;
      i_wr_data = d;
      i_stall   = st;
      i_flush   = fl;
      model_step(wr, d, st, fl);
      @(negedge i_clk);
      check_all(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".count"}, 64'(o_count),       64'd0);
      chk({tag, ".full"},  64'(o_full),        64'd0);
      chk({tag, ".af"},    64'(o_almost_full), 64'd0);
      chk({tag, ".ovf"},   64'(o_overflow),    64'd0);
      chk({tag, ".vld"},   64'(o_rd_valid),    64'd0);
      chk({tag, ".data"},  64'(o_rd_data),     64'd0);
   endtask

   initial begin
      m_ovf     = 1'b0;
      i_reset   = 1'b1;
      i_flush   = 1'b0;
      i_wr_en   = 1'b0;
      i_wr_data = '0;
      i_stall   = 1'b0;
      #2;
      check_reset_outputs("rst");
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;

      // Scenario 1: idle, then single write visible one cycle later
      cyc("idle", 1'b0, 32'h0, 1'b0, 1'b0);
      cyc("wr1", 1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
      chk("wr1.exp_data", 64'(o_rd_data), 64'hA5A5_0001);
      chk("wr1.exp_cnt",  64'(o_count),   64'd1);
      cyc("pop1", 1'b0, 32'h0, 1'b0, 1'b0);

      // Scenario 2: fill to full under stall, then overflow
      for (int i = 0; i < DEPTH; i++) begin
         cyc("fill", 1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
         if (i == 4) chk("fill.af_low5", 64'(o_almost_full), 64'd0);
         if (i == 5) chk("fill.af_at6",  64'(o_almost_full), 64'd1);
         if (i == 6) chk("fill.full7",   64'(o_full),        64'd0);
      end
      chk("fill.full8", 64'(o_full),  64'd1);
      chk("fill.cnt8",  64'(o_count), 64'd8);
      cyc("ovf", 1'b1, 32'h18, 1'b1, 1'b0);
      chk("ovf.flag", 64'(o_overflow), 64'd1);
      chk("ovf.head", 64'(o_rd_data),  64'h10);
      chk("ovf.cnt",  64'(o_count),    64'd8);

      // Scenario 3: drain with stall toggling 1,0,1,0...
      for (int i = 0; i < 2 * DEPTH; i++)
         cyc("drain", 1'b0, 32'h0, (i % 2 == 0), 1'b0);

      // Scenario 4: steady push+pop at count=3, wraps the pointers
      for (int i = 0; i < 3; i++) cyc("pre3", 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc("stream", 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
         chk("stream.cnt3", 64'(o_count), 64'd3);
      end
      for (int i = 0; i < 3; i++) cyc("post3", 1'b0, 32'h0, 1'b0, 1'b0);

      // Scenario 5: flush with a concurrent write at count=5
      for (int i = 0; i < 5; i++) cyc("pre5", 1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
      cyc("flush", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
      chk("flush.cnt", 64'(o_count),    64'd0);
      chk("flush.vld", 64'(o_rd_valid), 64'd0);
      chk("flush.ovf", 64'(o_overflow), 64'd0);
      cyc("flush.idle", 1'b0, 32'h0, 1'b0, 1'b0);

      // Scenario 6: random traffic with occasional flush
      for (int i = 0; i < 600; i++)
         cyc("rand", 1'($urandom_range(0, 99) < 60), $urandom,
             1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 63) == 0));

      // Scenario 7: asynchronous reset mid-burst
      for (int i = 0; i < 4; i++) cyc("burst", 1'b1, 32'h400 + 32'(i), 1'b1, 1'b0);
      i_wr_en   = 1'b1;
      i_wr_data = 32'h500;
      @(posedge i_clk);
      #2;
      i_reset = 1'b1;
      #1;
      check_reset_outputs("arst");
      q.delete();
      m_ovf   = 1'b0;
      i_wr_en = 1'b0;
      @(negedge i_clk);
      check_reset_outputs("arst.hold");
      i_reset = 1'b0;
      cyc("arst.wr1", 1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
      chk("arst.wr1_data", 64'(o_rd_data), 64'hA5A5_0001);
      chk("arst.wr1_vld",  64'(o_rd_valid), 64'd1);
      cyc("arst.pop", 1'b0, 32'h0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
